// File: rtl/sw_key_debounce_lbus.sv
// XT local-bus slave types and address-match helpers, followed by the
// push-button / slide-switch debounce peripheral.
//
// sw_key_debounce_lbus ports:
//   lb_clk   local-bus clock, the only clock
//   rst_n    asynchronous active-low reset
//   xt_lb    local-bus slave request (addr, rd, wr, wdata)
//   rdata    combinational read data, 0 when not addressed
//   irq      registered level interrupt
//   key_raw  asynchronous raw key pins
//   sw_raw   asynchronous raw switch pins
//
// Register map (16-bit, byte offsets from BASE_ADDR):
//   0x00 KEY_STATE RO, 0x02 SW_STATE RO, 0x04 KEY_PRESS W1C,
//   0x06 KEY_RELEASE W1C, 0x08 IRQ_EN RW (press [NUM_KEYS-1:0], release [NUM_KEYS+7:8])

package xt_bus_pkg;

  localparam int unsigned LB_AW = 16;
  localparam int unsigned LB_DW = 16;

  typedef struct packed {
    logic [LB_AW-1:0] addr;
    logic             rd;
    logic             wr;
    logic [LB_DW-1:0] wdata;
  } lb_slave_t;

  // Address falls inside the window of a slave at base (win_mask = offset bits).
  function automatic logic lb_in_window(input logic [LB_AW-1:0] addr,
                                        input logic [LB_AW-1:0] base,
                                        input logic [LB_AW-1:0] win_mask);
    return (addr & ~win_mask) == (base & ~win_mask);
  endfunction

  // Read strobe targeting this slave's window.
  function automatic logic lb_rd_match(input lb_slave_t        req,
                                       input logic [LB_AW-1:0] base,
                                       input logic [LB_AW-1:0] win_mask);
    return req.rd && lb_in_window(req.addr, base, win_mask);
  endfunction

  // Write strobe targeting one exact register address.
  function automatic logic lb_wr_match(input lb_slave_t        req,
                                       input logic [LB_AW-1:0] reg_addr);
    return req.wr && (req.addr == reg_addr);
  endfunction

endpackage

module sw_key_debounce_lbus
  import xt_bus_pkg::*;
#(
  parameter int unsigned NUM_KEYS        = 4,
  parameter int unsigned NUM_SW          = 3,
  parameter int unsigned DEBOUNCE_CYCLES = 20000,
  parameter bit          KEY_ACTIVE_LOW  = 1'b1,
  parameter logic [15:0] BASE_ADDR       = 16'h0000
) (
  input  logic                lb_clk,
  input  logic                rst_n,
  input  lb_slave_t           xt_lb,
  output logic [15:0]         rdata,
  output logic                irq,
  input  logic [NUM_KEYS-1:0] key_raw,
  input  logic [NUM_SW-1:0]   sw_raw
);

  localparam int unsigned NUM_IN = NUM_KEYS + NUM_SW;
  localparam int unsigned CNT_W  = (DEBOUNCE_CYCLES == 0) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST =
    (DEBOUNCE_CYCLES == 0) ? '0 : CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [15:0] WIN_MASK        = 16'h000F;
  localparam logic [3:0]  OFF_KEY_STATE   = 4'h0;
  localparam logic [3:0]  OFF_SW_STATE    = 4'h2;
  localparam logic [3:0]  OFF_KEY_PRESS   = 4'h4;
  localparam logic [3:0]  OFF_KEY_RELEASE = 4'h6;
  localparam logic [3:0]  OFF_IRQ_EN      = 4'h8;

  localparam logic [15:0] ADDR_KEY_PRESS   = BASE_ADDR + 16'(OFF_KEY_PRESS);
  localparam logic [15:0] ADDR_KEY_RELEASE = BASE_ADDR + 16'(OFF_KEY_RELEASE);
  localparam logic [15:0] ADDR_IRQ_EN      = BASE_ADDR + 16'(OFF_IRQ_EN);

  // Implemented IRQ_EN bits; release enables only exist when they fit below bit 16.
  localparam logic [31:0] KEY_ONES = (32'd1 << NUM_KEYS) - 32'd1;
  localparam logic [15:0] EN_MASK  =
    (NUM_KEYS <= 8) ? 16'(KEY_ONES | (KEY_ONES << 8)) : 16'(KEY_ONES);

  logic [NUM_IN-1:0]   raw_norm;
  logic [NUM_IN-1:0]   sync1;
  logic [NUM_IN-1:0]   sync2;
  logic [NUM_IN-1:0]   stable;
  logic [NUM_IN-1:0]   stable_nxt;
  logic [CNT_W-1:0]    cnt     [NUM_IN];
  logic [CNT_W-1:0]    cnt_nxt [NUM_IN];

  logic [NUM_KEYS-1:0] key_state;
  logic [NUM_KEYS-1:0] key_state_nxt;
  logic [NUM_SW-1:0]   sw_state;
  logic [NUM_KEYS-1:0] key_press;
  logic [NUM_KEYS-1:0] key_press_nxt;
  logic [NUM_KEYS-1:0] key_release;
  logic [NUM_KEYS-1:0] key_release_nxt;
  logic [NUM_KEYS-1:0] press_clr;
  logic [NUM_KEYS-1:0] release_clr;
  logic [NUM_KEYS-1:0] en_press;
  logic [NUM_KEYS-1:0] en_release;
  logic [15:0]         irq_en;
  logic [15:0]         irq_en_nxt;
  logic                irq_nxt;

  logic                rd_hit;
  logic                wr_press;
  logic                wr_release;
  logic                wr_irq_en;

  // Keys are normalised to 1 = pressed before the synchroniser, so the
  // all-zero reset value of the flops means "released" and cannot fake a press.
  assign raw_norm = {sw_raw, (KEY_ACTIVE_LOW ? ~key_raw : key_raw)};

  // Two-flop synchroniser for every raw pin.
  always_ff @(posedge lb_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw_norm;
      sync2 <= sync1;
    end
  end

  // Per-bit debounce: accept a new level after DEBOUNCE_CYCLES consecutive samples.
  always_comb begin
    stable_nxt = stable;
    for (int i = 0; i < NUM_IN; i++) begin
      cnt_nxt[i] = '0;
      if (DEBOUNCE_CYCLES == 0) begin
        stable_nxt[i] = sync2[i];
      end else if (sync2[i] != stable[i]) begin
        if (cnt[i] == CNT_LAST) begin
          stable_nxt[i] = sync2[i];
        end else begin
          cnt_nxt[i] = cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge lb_clk or negedge rst_n) begin
    if (!rst_n) begin
      stable <= '0;
      for (int i = 0; i < NUM_IN; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      stable <= stable_nxt;
      for (int i = 0; i < NUM_IN; i++) begin
        cnt[i] <= cnt_nxt[i];
      end
    end
  end

  assign key_state     = stable[NUM_KEYS-1:0];
  assign key_state_nxt = stable_nxt[NUM_KEYS-1:0];
  assign sw_state      = stable[NUM_IN-1:NUM_KEYS];

  // Bus decode.
  assign rd_hit     = lb_rd_match(xt_lb, BASE_ADDR, WIN_MASK);
  assign wr_press   = lb_wr_match(xt_lb, ADDR_KEY_PRESS);
  assign wr_release = lb_wr_match(xt_lb, ADDR_KEY_RELEASE);
  assign wr_irq_en  = lb_wr_match(xt_lb, ADDR_IRQ_EN);

  assign en_press = irq_en[NUM_KEYS-1:0];

  generate
    if (NUM_KEYS <= 8) begin : g_rel_en
      assign en_release = irq_en[NUM_KEYS+7:8];
    end else begin : g_rel_no_en
      assign en_release = '0;
    end
  endgenerate

  // Event flags: a hardware set in the same cycle as a W1C clear wins.
  always_comb begin
    press_clr       = wr_press   ? xt_lb.wdata[NUM_KEYS-1:0] : '0;
    release_clr     = wr_release ? xt_lb.wdata[NUM_KEYS-1:0] : '0;
    key_press_nxt   = (key_press & ~press_clr) | (key_state_nxt & ~key_state);
    key_release_nxt = (key_release & ~release_clr) | (~key_state_nxt & key_state);
    irq_en_nxt      = wr_irq_en ? (xt_lb.wdata & EN_MASK) : irq_en;
    irq_nxt         = (|(key_press & en_press)) | (|(key_release & en_release));
  end

  always_ff @(posedge lb_clk or negedge rst_n) begin
    if (!rst_n) begin
      key_press   <= '0;
      key_release <= '0;
      irq_en      <= '0;
      irq         <= 1'b0;
    end else begin
      key_press   <= key_press_nxt;
      key_release <= key_release_nxt;
      irq_en      <= irq_en_nxt;
      irq         <= irq_nxt;
    end
  end

  // Zero-wait-state read mux.
  always_comb begin
    rdata = '0;
    if (rd_hit) begin
      case (xt_lb.addr[3:0])
        OFF_KEY_STATE:   rdata = 16'(key_state);
        OFF_SW_STATE:    rdata = 16'(sw_state);
        OFF_KEY_PRESS:   rdata = 16'(key_press);
        OFF_KEY_RELEASE: rdata = 16'(key_release);
        OFF_IRQ_EN:      rdata = irq_en;
        default:         rdata = '0;
      endcase
    end
  end

endmodule
